motor_dosing: RTL and testbench
===============================

Name: motor_dosing

Overview:
- Dosing stage directly downstream of the paint-loading sequencer.
- Consumes the sequencer's one-hot `Motores` enables and drives each pigment motor (red, yellow, blue) for a time proportional to the latched quantity.
- Returns the per-channel completion `flags` that the sequencer waits on before advancing to the next pigment.

Parameters:
- W, 8, width of each quantity input, in dose units.
- TICKS_PER_UNIT, 1000, clock cycles of motor drive per dose unit (must be at least 1).
- CW, 24, width of the internal cycle counter (must be able to hold (2^W - 1) * TICKS_PER_UNIT).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load  input  1  one-cycle pulse: capture the three quantities.
- qty_r  input  W  red dose units.
- qty_y  input  W  yellow dose units.
- qty_b  input  W  blue dose units.
- Motores  input  3  one-hot channel enable from the sequencer; bit2 = red, bit1 = yellow, bit0 = blue.
- motor_drive  output  3  registered motor power, same bit order as Motores.
- flags  output  3  registered per-channel done, same bit order as Motores.
- busy  output  1  high while any channel is in RUN.
- fault  output  1  sticky: Motores was seen with more than one bit set.

Behaviour:
- Reset (async assert, sync release): motor_drive = 000, flags = 000, busy = 0, fault = 0, latched quantities = 0, all channels IDLE, counter = 0.
- Quantity latch:
  - On a clock edge with load = 1 and busy = 0, qty_r, qty_y and qty_b are registered.
  - load while busy = 1 is ignored; the latched values are unchanged.
- Channel FSM, one per channel k, states IDLE / RUN / DONE:
  - IDLE, Motores[k] = 1, Motores one-hot, latched qty != 0:
    - Go to RUN.
    - Counter loads qty * TICKS_PER_UNIT - 1.
    - motor_drive[k] = 1 from this edge.
  - IDLE, Motores[k] = 1, one-hot, latched qty == 0: go directly to DONE, flags[k] = 1 from this edge; motor never driven.
  - RUN: counter decrements once per cycle.
    - When counter = 0 at an edge: go to DONE, motor_drive[k] = 0 and flags[k] = 1 at that edge.
    - Net effect: motor_drive[k] is high for exactly qty * TICKS_PER_UNIT cycles, and flags[k] rises on the same edge that drive falls.
  - RUN, Motores[k] drops before completion (abort):
    - Go to IDLE at the next edge, motor_drive[k] = 0.
    - No flag is raised; the counter is discarded.
  - DONE: flags[k] held high while Motores[k] = 1. When Motores[k] = 0 at an edge: flags[k] = 0, go to IDLE.
- Non-one-hot Motores (two or more bits set):
  - No IDLE channel starts.
  - fault set to 1 and held until reset.
  - Any channel already in RUN continues while its own bit stays high.
- A single shared counter is sufficient: at most one channel is in RUN at a time because starts require one-hot Motores.
- Restart after DONE requires Motores[k] to return to 0 first; a level held high never re-triggers a dose.
- busy = 1 exactly when some channel is in RUN.
- Arithmetic: qty * TICKS_PER_UNIT is computed at CW bits, unsigned, with no saturation. The parameter constraint guarantees no overflow.
- Reset asserted mid-dose: all outputs drop asynchronously to their reset values. Latched quantities are cleared, so a new load is required.
- Sequencer timing: the sequencer sees flags[k] and changes state on the following edge, which drops Motores[k]. flags[k] is therefore high for at least one cycle, and typically exactly one cycle after Motores[k] falls is visible.

Test Plan:
- TICKS_PER_UNIT = 4. Load qty_r = 3, qty_y = 1, qty_b = 2, then step Motores 100 -> 010 -> 001, dropping each bit one cycle after its flag -> motor_drive[2] high 12 cycles, [1] 4 cycles, [0] 8 cycles. Each flag rises on the edge its drive falls and clears when its Motores bit drops.
- qty_y = 0, Motores = 010 -> flags[1] = 1 one edge later, motor_drive stays 000, busy stays 0.
- Red dose (qty 5) running, Motores drops to 000 after 7 cycles -> motor_drive = 000 next edge, flags stay 000. Reasserting 100 restarts a full 20-cycle dose.
- load with qty_r = 9 pulsed while red is in RUN -> current dose unaffected. After busy = 0, a new red dose still uses the old value.
- Motores = 110 from idle -> fault = 1, no drive. Fault persists after Motores returns to 000, until reset.
- reset pulled low 5 cycles into a blue dose -> motor_drive, flags, busy = 0 immediately (asynchronous). After release with Motores = 001 and qty = 0, flags[0] = 1 one edge later.

Source files
------------

// File: rtl/motor_dosing.sv
// Pigment motor dosing stage: runs the enabled motor for qty * TICKS_PER_UNIT cycles
// and reports per-channel completion flags back to the loading sequencer.
module motor_dosing #(
  parameter int W              = 8,
  parameter int TICKS_PER_UNIT = 1000,
  parameter int CW             = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] qty_r,
  input  logic [W-1:0] qty_y,
  input  logic [W-1:0] qty_b,
  input  logic [2:0]   Motores,
  output logic [2:0]   motor_drive,
  output logic [2:0]   flags,
  output logic         busy,
  output logic         fault
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam logic [CW-1:0] TPU = CW'(TICKS_PER_UNIT);

  // Channel index follows the Motores bit order: 2 = red, 1 = yellow, 0 = blue.
  state_e        state_q [3];
  state_e        state_d [3];
  logic [W-1:0]  qty_q   [3];
  logic [W-1:0]  qty_d   [3];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    drive_q, drive_d;
  logic [2:0]    flags_q, flags_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  logic          one_hot;
  logic          multi_hot;

  assign one_hot   = $onehot(Motores);
  assign multi_hot = (Motores != 3'b000) && !one_hot;

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block leaves a
    // variable unassigned; that is what keeps it free of inferred latches.
    state_d = state_q;
    qty_d   = qty_q;
    cnt_d   = cnt_q;
    drive_d = drive_q;
    flags_d = flags_q;
    fault_d = fault_q | multi_hot;

    if (load && !busy_q) begin
      qty_d[2] = qty_r;
      qty_d[1] = qty_y;
      qty_d[0] = qty_b;
    end

    // Starts need one-hot Motores, so at most one channel ever owns the counter.
    for (int k = 0; k < 3; k++) begin
      case (state_q[k])
        ST_IDLE: begin
          if (Motores[k] && one_hot) begin
            if (qty_q[k] != '0) begin
              state_d[k] = ST_RUN;
              drive_d[k] = 1'b1;
              cnt_d      = CW'(qty_q[k]) * TPU - CW'(1);
            end else begin
              state_d[k] = ST_DONE;
              flags_d[k] = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!Motores[k]) begin
            state_d[k] = ST_IDLE;
            drive_d[k] = 1'b0;
            cnt_d      = '0;
          end else if (cnt_q == '0) begin
            state_d[k] = ST_DONE;
            drive_d[k] = 1'b0;
            flags_d[k] = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_DONE: begin
          if (!Motores[k]) begin
            state_d[k] = ST_IDLE;
            flags_d[k] = 1'b0;
          end
        end
        default: begin
          state_d[k] = ST_IDLE;
          drive_d[k] = 1'b0;
          flags_d[k] = 1'b0;
        end
      endcase
    end

    busy_d = 1'b0;
    for (int k = 0; k < 3; k++) begin
      busy_d = busy_d | (state_d[k] == ST_RUN);
    end
  end

  // NOTE: asynchronous active-low reset; sequential state uses non-blocking
  // assignments only so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= ST_IDLE;
        qty_q[k]   <= '0;
      end
      cnt_q   <= '0;
      drive_q <= 3'b000;
      flags_q <= 3'b000;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      qty_q   <= qty_d;
      cnt_q   <= cnt_d;
      drive_q <= drive_d;
      flags_q <= flags_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign motor_drive = drive_q;
  assign flags       = flags_q;
  assign busy        = busy_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_motor_dosing.sv
// Directed bench for motor_dosing with TICKS_PER_UNIT = 4: full dose sequence,
// zero quantity, abort, load-while-busy, fault and asynchronous reset.
module tb_motor_dosing;

  localparam int W   = 8;
  localparam int TPU = 4;
  localparam int CW  = 24;

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] qty_r, qty_y, qty_b;
  logic [2:0]   Motores;
  logic [2:0]   motor_drive;
  logic [2:0]   flags;
  logic         busy;
  logic         fault;

  int n_checks = 0;
  int n_fail   = 0;

  motor_dosing #(.W(W), .TICKS_PER_UNIT(TPU), .CW(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .qty_r      (qty_r),
    .qty_y      (qty_y),
    .qty_b      (qty_b),
    .Motores    (Motores),
    .motor_drive(motor_drive),
    .flags      (flags),
    .busy       (busy),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic [W-1:0] qr, qy, qb;
    logic [2:0]   mot;
    logic [2:0]   drive;
    logic [2:0]   flg;
    logic         bsy;
    logic         flt;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one dose on channel k, counting the cycles its drive is high; optionally
  // pulses load with qty 9 mid-dose, which must be ignored.
  task automatic run_dose(input int k, input int exp_len, input bit do_load);
    int cnt;
    int guard;
    logic [2:0] bit_k;
    bit_k   = 3'b001 << k;
    Motores = bit_k;
    step();
    check($sformatf("ch%0d_start_drive", k), 32'(motor_drive), 32'(bit_k));
    check($sformatf("ch%0d_start_busy", k), 32'(busy), 32'd1);
    cnt   = 1;
    guard = 0;
    while (motor_drive[k] && guard < 200) begin
      if (do_load && cnt == 3) begin
        load  = 1'b1;
        qty_r = 8'd9;
        qty_y = 8'd9;
        qty_b = 8'd9;
      end
      step();
      load = 1'b0;
      guard++;
      if (motor_drive[k]) cnt++;
    end
    check($sformatf("ch%0d_dose_len", k), 32'(cnt), 32'(exp_len));
    check($sformatf("ch%0d_done_flags", k), 32'(flags), 32'(bit_k));
    check($sformatf("ch%0d_done_drive", k), 32'(motor_drive), 32'd0);
    check($sformatf("ch%0d_done_busy", k), 32'(busy), 32'd0);
    step();
    check($sformatf("ch%0d_flag_hold", k), 32'(flags), 32'(bit_k));
    check($sformatf("ch%0d_no_retrigger", k), 32'(motor_drive), 32'd0);
    Motores = 3'b000;
    step();
    check($sformatf("ch%0d_flag_clear", k), 32'(flags), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd5, 8'd0, 8'd2, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b010, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'd0, 8'd0, 8'd0, 3'b010, 3'b000, 3'b010, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'd0, 8'd0, 8'd0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0};

    reset   = 1'b0;
    load    = 1'b0;
    qty_r   = '0;
    qty_y   = '0;
    qty_b   = '0;
    Motores = 3'b000;
    step();
    step();
    check("rst_drive", 32'(motor_drive), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    reset = 1'b1;

    load  = 1'b1;
    qty_r = 8'd3;
    qty_y = 8'd1;
    qty_b = 8'd2;
    step();
    load = 1'b0;
    check("load_busy", 32'(busy), 32'd0);
    run_dose(2, 12, 1'b0);
    run_dose(1, 4, 1'b0);
    run_dose(0, 8, 1'b0);

    // Latch red 5 / yellow 0 / blue 2, then the zero-quantity yellow channel.
    for (int i = 0; i < 4; i++) begin
      load    = tbl[i].load;
      qty_r   = tbl[i].qr;
      qty_y   = tbl[i].qy;
      qty_b   = tbl[i].qb;
      Motores = tbl[i].mot;
      step();
      check($sformatf("vec%0d_drive", i), 32'(motor_drive), 32'(tbl[i].drive));
      check($sformatf("vec%0d_flags", i), 32'(flags), 32'(tbl[i].flg));
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("vec%0d_fault", i), 32'(fault), 32'(tbl[i].flt));
    end
    load = 1'b0;

    // Abort a red dose after 7 driven cycles.
    Motores = 3'b100;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("abort_drive_c%0d", i), 32'(motor_drive), 32'b100);
    end
    Motores = 3'b000;
    step();
    check("abort_drive", 32'(motor_drive), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);

    run_dose(2, 20, 1'b1);
    run_dose(2, 20, 1'b0);

    Motores = 3'b110;
    step();
    check("multi_drive", 32'(motor_drive), 32'd0);
    check("multi_fault", 32'(fault), 32'd1);
    check("multi_busy", 32'(busy), 32'd0);
    Motores = 3'b000;
    step();
    step();
    check("fault_sticky", 32'(fault), 32'd1);

    // Blue dose interrupted by asynchronous reset.
    Motores = 3'b001;
    for (int i = 0; i < 5; i++) step();
    check("pre_rst_drive", 32'(motor_drive), 32'b001);
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_drive", 32'(motor_drive), 32'd0);
    check("async_rst_flags", 32'(flags), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_fault", 32'(fault), 32'd0);
    step();
    reset = 1'b1;
    step();
    check("post_rst_flags", 32'(flags), 32'b001);
    check("post_rst_drive", 32'(motor_drive), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    Motores = 3'b000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
